// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared Simon Says types and constants
package simon_pkg;

    typedef logic [2:0] color_t;

    localparam int NUM_SEGMENTS = 32;
    localparam int NUM_BUTTONS  = 4;

    localparam color_t COLOR_0 = 3'd0;
    localparam color_t COLOR_1 = 3'd1;
    localparam color_t COLOR_2 = 3'd2;
    localparam color_t COLOR_3 = 3'd3;

endpackage

// File: rtl/color_decode.sv
// rtl/color_decode.sv - colour code to one-hot button decoder
import simon_pkg::*;

module color_decode (
    input  logic [2:0] code,
    output logic [3:0] buttons
);

    // Codes 4-7 are not colours; they decode to no button at all.
    always_comb begin
        buttons = 4'b0000;
        case (code)
            COLOR_0: buttons = 4'b0001;
            COLOR_1: buttons = 4'b0010;
            COLOR_2: buttons = 4'b0100;
            COLOR_3: buttons = 4'b1000;
            default: buttons = 4'b0000;
        endcase
    end

endmodule

// File: rtl/verify_input.sv
// rtl/verify_input.sv - registered check of a button press against the active round
import simon_pkg::*;

module verify_input (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0][2:0] segment,
    input  logic [3:0]      player_input,
    input  logic [4:0]      check_round,
    output logic            result,
    output logic            empty
);

    color_t     exp_code;
    logic [3:0] exp_buttons;
    logic       code_valid;
    logic       press_one_hot;
    logic       result_next;
    logic       empty_next;

    assign exp_code = segment[check_round];

    color_decode u_color_decode (
        .code    (exp_code),
        .buttons (exp_buttons)
    );

    assign code_valid = (exp_code <= COLOR_3);

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign press_one_hot = (player_input != 4'b0000) &&
                           ((player_input & (player_input - 4'd1)) == 4'b0000);

    assign result_next = press_one_hot && code_valid && (player_input == exp_buttons);
    assign empty_next  = (player_input == 4'b0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= 1'b0;
            empty  <= 1'b1;
        end else begin
            result <= result_next;
            empty  <= empty_next;
        end
    end

endmodule

// File: tb/tb_verify_input.sv
// tb/tb_verify_input.sv - self-checking bench for verify_input
module tb_verify_input;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0][2:0] segment;
    logic [3:0]       player_input;
    logic [4:0]       check_round;
    logic             result;
    logic             empty;

    int total = 0;
    int bad   = 0;

    logic m_valid  = 1'b0;
    logic m_result = 1'b0;
    logic m_empty  = 1'b1;

    verify_input dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .segment      (segment),
        .player_input (player_input),
        .check_round  (check_round),
        .result       (result),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a press passes when exactly one button is down and it is
    // button number <code>, with code a real colour (below 4).
    function automatic logic [1:0] model(input logic [31:0][2:0] seg,
                                         input logic [4:0] rnd,
                                         input logic [3:0] p);
        int ones = 0;
        int code;
        logic r;
        for (int b = 0; b < 4; b++) ones += int'(p[b]);
        code = int'(seg[rnd]);
        r = (ones == 1) && (code < 4) && (int'(p) == (1 << code));
        return {r, (ones == 0)};
    endfunction

    always @(posedge clk) begin
        logic [1:0] m;
        m = model(segment, check_round, player_input);
        m_valid <= 1'b1;
        if (!rst_n) begin
            m_result <= 1'b0;
            m_empty  <= 1'b1;
        end else begin
            m_result <= m[1];
            m_empty  <= m[0];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_result", result, m_result);
            chk("model_empty", empty, m_empty);
        end
    end

    task automatic drive(input logic rn, input logic [4:0] rnd, input logic [3:0] p);
        @(negedge clk);
        #1;
        rst_n        = rn;
        check_round  = rnd;
        player_input = p;
    endtask

    task automatic expect_lit(input string name, input logic r, input logic e);
        @(posedge clk);
        #1;
        chk({name, "_result"}, result, r);
        chk({name, "_empty"}, empty, e);
    endtask

    initial begin
        rst_n        = 1'b0;
        player_input = 4'b1011;
        check_round  = 5'd7;
        for (int i = 0; i < 32; i++) segment[i] = 3'($urandom_range(0, 7));

        // Reset with arbitrary inputs, then release with no press.
        expect_lit("reset", 1'b0, 1'b1);
        drive(1'b0, 5'd2, 4'b0100);
        expect_lit("reset_override", 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) segment[i] = 3'(i % 5);
        drive(1'b1, 5'd2, 4'b0000);
        expect_lit("release_empty", 1'b0, 1'b1);

        drive(1'b1, 5'd2, 4'b0100);
        expect_lit("match", 1'b1, 1'b0);
        drive(1'b1, 5'd3, 4'b0001);
        expect_lit("mismatch", 1'b0, 1'b0);
        drive(1'b1, 5'd3, 4'b0000);
        expect_lit("empty_press", 1'b0, 1'b1);
        drive(1'b1, 5'd4, 4'b0001);
        expect_lit("invalid_code", 1'b0, 1'b0);
        drive(1'b1, 5'd4, 4'b0000);
        expect_lit("invalid_empty", 1'b0, 1'b1);
        drive(1'b1, 5'd1, 4'b0011);
        expect_lit("multi_press", 1'b0, 1'b0);
        drive(1'b1, 5'd1, 4'b1111);
        expect_lit("all_press", 1'b0, 1'b0);

        // Sweep every round, correct press for valid codes, new round each cycle.
        for (int r = 0; r < 32; r++) begin
            int code;
            logic [3:0] p;
            code = r % 5;
            p = (code < 4) ? 4'(1 << code) : 4'b0001;
            drive(1'b1, 5'(r), p);
            expect_lit($sformatf("sweep%0d", r), (code < 4), 1'b0);
        end

        // Randomised traffic, checked every cycle by the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            rst_n       = ($urandom_range(0, 19) != 0);
            check_round = 5'($urandom);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 32; i++) segment[i] = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: player_input = 4'($urandom);
                1: player_input = 4'b0000;
                default: player_input = (segment[check_round] < 3'd4) ?
                                        4'(1 << segment[check_round]) : 4'(1 << $urandom_range(0, 3));
            endcase
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
